// File: rtl/id_reg_scoreboard.sv
// id_reg_scoreboard
//
// Per-register in-flight write scoreboard for the decode stage. Each general
// register r1..r31 has a CNT_W-bit counter of outstanding writes. A counter
// increments when a writing instruction leaves decode and decrements when
// that instruction writes back. Decode stalls on a read of a busy register
// or when the destination counter is already full. r0 is never tracked.
//
// Optional feature macro: SCB_WB_BYPASS_EN
//   Defined: a source hazard is masked when the last outstanding write to that
//   register is writing back this cycle. The register file write-through read
//   supplies the value, so the consumer issues in the writeback cycle.
//   Undefined: hazards use registered counts only.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-high reset, clears all state
//   id_valid      decode holds a valid instruction
//   src1_en/src1  rj read enable / index
//   src2_en/src2  rk/rd read enable / index
//   dst_we/dst    instruction writes a register / destination index
//   issue_fire    decode->execute handshake completes this cycle
//   wb_we/wb_dest writeback register-file write / destination index
//   stall         combinational; decode must not issue
//   busy_mask     registered; bit i set iff counter i is non-zero
//   inflight      registered; total outstanding writes, saturating at 63
//   underflow_err registered, sticky; a retire hit a zero counter
module id_reg_scoreboard #(
    parameter int unsigned CNT_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic        src1_en,
    input  logic [4:0]  src1,
    input  logic        src2_en,
    input  logic [4:0]  src2,
    input  logic        dst_we,
    input  logic [4:0]  dst,
    input  logic        issue_fire,
    input  logic        wb_we,
    input  logic [4:0]  wb_dest,
    output logic        stall,
    output logic [31:0] busy_mask,
    output logic [5:0]  inflight,
    output logic        underflow_err
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    // Entry 0 exists only so register indices can be used directly; it is
    // held at zero.
    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic [31:0]      busy_mask_q, busy_mask_d;
    logic [5:0]       inflight_q, inflight_d;
    logic             underflow_err_q, underflow_err_d;

    logic             haz1, haz2, ovf, inc, dec;
    logic [31:0]      inc_vec, dec_vec;

    // Hazard detection and stall.
    always_comb begin
        haz1 = src1_en && (src1 != 5'd0) && (cnt_q[src1] != '0);
        haz2 = src2_en && (src2 != 5'd0) && (cnt_q[src2] != '0);
`ifdef SCB_WB_BYPASS_EN
        if (wb_we && (wb_dest == src1) && (cnt_q[src1] == CntOne)) begin
            haz1 = 1'b0;
        end
        if (wb_we && (wb_dest == src2) && (cnt_q[src2] == CntOne)) begin
            haz2 = 1'b0;
        end
`endif
        ovf   = dst_we && (dst != 5'd0) && (cnt_q[dst] == CntMax);
        stall = id_valid && (haz1 || haz2 || ovf);
    end

    assign inc     = issue_fire && dst_we && (dst != 5'd0);
    assign dec     = wb_we && (wb_dest != 5'd0);
    assign inc_vec = inc ? (32'd1 << dst) : 32'd0;
    assign dec_vec = dec ? (32'd1 << wb_dest) : 32'd0;

    // Counter, busy mask and underflow next state.
    always_comb begin
        underflow_err_d = underflow_err_q;
        busy_mask_d     = '0;
        cnt_d[0]        = '0;
        for (int i = 1; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc_vec[i] && !dec_vec[i]) begin
                // Protocol-violating issue past a full counter simply wraps.
                cnt_d[i] = cnt_q[i] + CntOne;
            end else if (dec_vec[i] && !inc_vec[i]) begin
                if (cnt_q[i] == '0) begin
                    underflow_err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CntOne;
                end
            end
            busy_mask_d[i] = (cnt_d[i] != '0);
        end
    end

    // Total in-flight count, clamped to 0..63.
    always_comb begin
        inflight_d = inflight_q;
        if (inc && !dec && (inflight_q != 6'd63)) begin
            inflight_d = inflight_q + 6'd1;
        end else if (dec && !inc && (inflight_q != 6'd0)) begin
            inflight_d = inflight_q - 6'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
            busy_mask_q     <= '0;
            inflight_q      <= '0;
            underflow_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            busy_mask_q     <= busy_mask_d;
            inflight_q      <= inflight_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    assign busy_mask     = busy_mask_q;
    assign inflight      = inflight_q;
    assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_id_reg_scoreboard.sv
// Self-checking bench for id_reg_scoreboard (CNT_W = 2). Each scenario task
// builds a table of per-cycle stimulus rows with the expected outputs for
// that cycle, pushes the expectation into a scoreboard queue as the row is
// driven, and pops/compares it at the following falling edge.
module tb_id_reg_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, src1_en, src2_en, dst_we, issue_fire, wb_we;
    logic [4:0]  src1, src2, dst, wb_dest;
    logic        stall;
    logic [31:0] busy_mask;
    logic [5:0]  inflight;
    logic        underflow_err;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        idv;
        logic        s1e;
        logic [4:0]  s1;
        logic        s2e;
        logic [4:0]  s2;
        logic        dwe;
        logic [4:0]  d;
        logic        fire;
        logic        wbwe;
        logic [4:0]  wbd;
        logic        xst;
        logic [31:0] xbusy;
        logic [5:0]  xinf;
        logic        xuf;
    } stim_t;

    stim_t exp_q[$];

    id_reg_scoreboard #(.CNT_W(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .src1_en       (src1_en),
        .src1          (src1),
        .src2_en       (src2_en),
        .src2          (src2),
        .dst_we        (dst_we),
        .dst           (dst),
        .issue_fire    (issue_fire),
        .wb_we         (wb_we),
        .wb_dest       (wb_dest),
        .stall         (stall),
        .busy_mask     (busy_mask),
        .inflight      (inflight),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic stim_t row(input int idv, input int s1e, input int s1, input int s2e,
                                  input int s2, input int dwe, input int d, input int fire,
                                  input int wbwe, input int wbd, input int xst,
                                  input logic [31:0] xbusy, input int xinf, input int xuf);
        stim_t s;
        s.idv  = 1'(idv);  s.s1e  = 1'(s1e);  s.s1  = 5'(s1);
        s.s2e  = 1'(s2e);  s.s2   = 5'(s2);   s.dwe = 1'(dwe);
        s.d    = 5'(d);    s.fire = 1'(fire); s.wbwe = 1'(wbwe);
        s.wbd  = 5'(wbd);  s.xst  = 1'(xst);  s.xbusy = xbusy;
        s.xinf = 6'(xinf); s.xuf  = 1'(xuf);
        return s;
    endfunction

    task automatic apply(input stim_t s);
        id_valid = s.idv;  src1_en = s.s1e; src1 = s.s1;
        src2_en  = s.s2e;  src2    = s.s2;  dst_we = s.dwe;
        dst      = s.d;    issue_fire = s.fire;
        wb_we    = s.wbwe; wb_dest = s.wbd;
    endtask

    task automatic test_reset();
        stim_t rows[$];
        stim_t e;
        reset = 1'b1;
        apply(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        #2;
        if (busy_mask !== 32'h0) begin miscompares++;
            $display("FAIL reset busy_mask: got %h expected 0", busy_mask); end
        vectors++;
        if (inflight !== 6'd0) begin miscompares++;
            $display("FAIL reset inflight: got %0d expected 0", inflight); end
        vectors++;
        if (stall !== 1'b0) begin miscompares++;
            $display("FAIL reset stall: got %b expected 0", stall); end
        vectors++;
        if (underflow_err !== 1'b0) begin miscompares++;
            $display("FAIL reset underflow_err: got %b expected 0", underflow_err); end
        vectors++;
        @(negedge clk);
        reset = 1'b0;
        rows.push_back(row(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 32'h0, 0, 0));
        rows.push_back(row(1, 1, 5, 0, 0, 1, 6, 0, 0, 0, 1, 32'h20, 1, 0));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            apply(rows[i]);
            exp_q.push_back(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            if (stall !== e.xst) begin miscompares++;
                $display("FAIL reset[%0d] stall: got %b expected %b", i, stall, e.xst); end
            vectors++;
            if (busy_mask !== e.xbusy) begin miscompares++;
                $display("FAIL reset[%0d] busy_mask: got %h expected %h", i, busy_mask, e.xbusy); end
            vectors++;
            if (inflight !== e.xinf) begin miscompares++;
                $display("FAIL reset[%0d] inflight: got %0d expected %0d", i, inflight, e.xinf); end
            vectors++;
        end
        // Mid-cycle asynchronous reset with r5 busy and a consumer of r5 present.
        #2 reset = 1'b1;
        #1;
        if (busy_mask !== 32'h0) begin miscompares++;
            $display("FAIL midreset busy_mask: got %h expected 0", busy_mask); end
        vectors++;
        if (inflight !== 6'd0) begin miscompares++;
            $display("FAIL midreset inflight: got %0d expected 0", inflight); end
        vectors++;
        if (stall !== 1'b0) begin miscompares++;
            $display("FAIL midreset stall: got %b expected 0", stall); end
        vectors++;
        #1 reset = 1'b0;
        @(posedge clk); #1;
        apply(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
    endtask

    task automatic test_raw();
        stim_t rows[$];
        stim_t e;
        rows.push_back(row(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 32'h0, 0, 0));
        for (int c = 1; c <= 3; c++)
            rows.push_back(row(1, 1, 5, 0, 0, 1, 6, 0, 0, 0, 1, 32'h20, 1, 0));
`ifdef SCB_WB_BYPASS_EN
        rows.push_back(row(1, 1, 5, 0, 0, 1, 6, 1, 1, 5, 0, 32'h20, 1, 0));
        rows.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40, 1, 0));
`else
        rows.push_back(row(1, 1, 5, 0, 0, 1, 6, 0, 1, 5, 1, 32'h20, 1, 0));
        rows.push_back(row(1, 1, 5, 0, 0, 1, 6, 1, 0, 0, 0, 32'h0, 0, 0));
`endif
        rows.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 32'h40, 1, 0));
        rows.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            apply(rows[i]);
            exp_q.push_back(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            if (stall !== e.xst) begin miscompares++;
                $display("FAIL raw[%0d] stall: got %b expected %b", i, stall, e.xst); end
            vectors++;
            if (busy_mask !== e.xbusy) begin miscompares++;
                $display("FAIL raw[%0d] busy_mask: got %h expected %h", i, busy_mask, e.xbusy); end
            vectors++;
            if (inflight !== e.xinf) begin miscompares++;
                $display("FAIL raw[%0d] inflight: got %0d expected %0d", i, inflight, e.xinf); end
            vectors++;
        end
    endtask

    task automatic test_waw_saturation();
        stim_t rows[$];
        stim_t e;
        rows.push_back(row(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0, 32'h0, 0, 0));
        rows.push_back(row(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0, 32'h80, 1, 0));
        rows.push_back(row(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0, 32'h80, 2, 0));
        // cnt[7] = 3: a fourth writer of r7 must stall.
        rows.push_back(row(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 32'h80, 3, 0));
        rows.push_back(row(1, 0, 0, 0, 0, 1, 7, 0, 1, 7, 1, 32'h80, 3, 0));
        rows.push_back(row(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0, 32'h80, 2, 0));
        rows.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 32'h80, 3, 0));
        rows.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 32'h80, 2, 0));
        rows.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 32'h80, 1, 0));
        rows.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            apply(rows[i]);
            exp_q.push_back(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            if (stall !== e.xst) begin miscompares++;
                $display("FAIL waw[%0d] stall: got %b expected %b", i, stall, e.xst); end
            vectors++;
            if (busy_mask !== e.xbusy) begin miscompares++;
                $display("FAIL waw[%0d] busy_mask: got %h expected %h", i, busy_mask, e.xbusy); end
            vectors++;
            if (inflight !== e.xinf) begin miscompares++;
                $display("FAIL waw[%0d] inflight: got %0d expected %0d", i, inflight, e.xinf); end
            vectors++;
        end
    endtask

    task automatic test_same_cycle();
        stim_t rows[$];
        stim_t e;
        rows.push_back(row(1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0, 32'h0, 0, 0));
        rows.push_back(row(1, 0, 0, 0, 0, 1, 9, 1, 1, 9, 0, 32'h200, 1, 0));
        // Count must still be 1 after the simultaneous issue and retire.
        rows.push_back(row(1, 0, 0, 1, 9, 0, 0, 0, 0, 0, 1, 32'h200, 1, 0));
        rows.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 32'h200, 1, 0));
        rows.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            apply(rows[i]);
            exp_q.push_back(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            if (stall !== e.xst) begin miscompares++;
                $display("FAIL same[%0d] stall: got %b expected %b", i, stall, e.xst); end
            vectors++;
            if (busy_mask !== e.xbusy) begin miscompares++;
                $display("FAIL same[%0d] busy_mask: got %h expected %h", i, busy_mask, e.xbusy); end
            vectors++;
            if (inflight !== e.xinf) begin miscompares++;
                $display("FAIL same[%0d] inflight: got %0d expected %0d", i, inflight, e.xinf); end
            vectors++;
        end
    endtask

    task automatic test_r0();
        stim_t rows[$];
        stim_t e;
        rows.push_back(row(1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 32'h0, 0, 0));
        rows.push_back(row(1, 1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 32'h0, 0, 0));
        rows.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            apply(rows[i]);
            exp_q.push_back(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            if (stall !== e.xst) begin miscompares++;
                $display("FAIL r0[%0d] stall: got %b expected %b", i, stall, e.xst); end
            vectors++;
            if (busy_mask !== e.xbusy) begin miscompares++;
                $display("FAIL r0[%0d] busy_mask: got %h expected %h", i, busy_mask, e.xbusy); end
            vectors++;
            if (inflight !== e.xinf) begin miscompares++;
                $display("FAIL r0[%0d] inflight: got %0d expected %0d", i, inflight, e.xinf); end
            vectors++;
            if (underflow_err !== e.xuf) begin miscompares++;
                $display("FAIL r0[%0d] underflow_err: got %b expected %b", i, underflow_err, e.xuf); end
            vectors++;
        end
    endtask

    task automatic test_underflow();
        stim_t rows[$];
        stim_t e;
        rows.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 32'h0, 0, 0));
        rows.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1));
        rows.push_back(row(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 32'h0, 0, 1));
        // A single issue after the bad retire leaves r3 busy: the count stayed 0.
        rows.push_back(row(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8, 1, 1));
        rows.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 32'h8, 1, 1));
        rows.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            apply(rows[i]);
            exp_q.push_back(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            if (stall !== e.xst) begin miscompares++;
                $display("FAIL uf[%0d] stall: got %b expected %b", i, stall, e.xst); end
            vectors++;
            if (busy_mask !== e.xbusy) begin miscompares++;
                $display("FAIL uf[%0d] busy_mask: got %h expected %h", i, busy_mask, e.xbusy); end
            vectors++;
            if (inflight !== e.xinf) begin miscompares++;
                $display("FAIL uf[%0d] inflight: got %0d expected %0d", i, inflight, e.xinf); end
            vectors++;
            if (underflow_err !== e.xuf) begin miscompares++;
                $display("FAIL uf[%0d] underflow_err: got %b expected %b", i, underflow_err, e.xuf); end
            vectors++;
        end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_waw_saturation();
        test_same_cycle();
        test_r0();
        test_underflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
